// File: rtl/pwm_generator.sv
// ---------------------------------------------------------------------------
// pwm_generator
//
// Drives the 16 user outputs from the SPI configuration registers. Each output
// is held low, driven constant high, or driven with one shared PWM waveform.
// The PWM frequency is clk / (CLK_DIV * 256). The duty cycle is double
// buffered. It is loaded into the active duty register only when the 8-bit
// PWM counter wraps, so a waveform never glitches mid-period.
//
// Parameters
//   CLK_DIV          system clocks per PWM count tick (>= 1)
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable for out[7:0]   (1 = driven)
//   en_reg_out_15_8  output enable for out[15:8]
//   en_reg_pwm_7_0   PWM mode for out[7:0]        (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  PWM mode for out[15:8]
//   pwm_duty_cycle   requested duty cycle, applied at the next wrap
//   out              registered user outputs
//   period_start     one-clock pulse in the cycle the PWM count restarts at 0
// ---------------------------------------------------------------------------
module pwm_generator #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // A divide-by-1 prescaler still needs a one-bit register so the
    // declarations below stay legal.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic [15:0]   out_q, out_d;
    logic          ps_q, ps_d;

    logic          tick;
    logic          wrap;
    logic          pwm;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Next-state logic for the prescaler, the PWM counter and the duty shadow.
    // The waveform is compared against the active duty, never the requested
    // one. 0xFF is forced high so that full duty has no low cycle at the wrap.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        wrap    = tick && (cnt_q == 8'hFF);
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
        duty_d  = wrap ? pwm_duty_cycle : duty_q;
        pwm     = (duty_q == 8'hFF) || (cnt_q < duty_q);
        // A disabled bit is low. An enabled bit is high unless it is in
        // PWM mode, where it follows the shared waveform.
        out_d   = en_out & (~en_pwm | {16{pwm}});
        ps_d    = wrap;
    end

    // All state is cleared asynchronously, whatever the phase of the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            out_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            out_q   <= out_d;
            ps_q    <= ps_d;
        end
    end

    assign out          = out_q;
    assign period_start = ps_q;

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Consumes the five configuration registers written over SPI (output enables, PWM-mode enables, duty cycle) and drives the 16 user outputs. Each output is held low, driven constant high, or driven with one shared PWM waveform of about 3 kHz. The block sits directly downstream of the SPI register file and upstream of the output pads. The duty cycle is double-buffered and takes effect only at a period boundary, so output waveforms never glitch.

## Interface
- CLK_DIV, 13: system clocks per PWM count tick; must be ≥1. At 10 MHz the PWM frequency is 10e6/(13·256) ≈ 3004 Hz.
- clk  input  1  system clock. One clock domain; reset is asynchronous and active-low.
- rst_n  input  1  asynchronous active-low reset.
- en_reg_out_7_0  input  8  output enable for out[7:0]. 1 = output driven.
- en_reg_out_15_8  input  8  output enable for out[15:8].
- en_reg_pwm_7_0  input  8  PWM mode for out[7:0]. 1 = PWM, 0 = static high (when enabled).
- en_reg_pwm_15_8  input  8  PWM mode for out[15:8].
- pwm_duty_cycle  input  8  requested duty cycle, 0x00–0xFF.
- out  output  16  registered user outputs.
- period_start  output  1  one-clk pulse in the cycle the PWM count becomes 0 after a wrap.

## Operation
- All inputs are already synchronous to clk. No input synchronizers.
- **Prescaler `presc`:**
  - width max(1, $clog2(CLK_DIV)); counts 0..CLK_DIV-1, then wraps to 0.
  - `tick` = (presc == CLK_DIV-1). With CLK_DIV=1, tick is 1 every cycle.
- **PWM counter `cnt`:**
  - 8 bits; increments on tick and wraps 255→0.
  - A wrap is tick && cnt==255.
- **Duty shadow `duty_act`:**
  - 8 bits; reset value 0.
  - On a wrap it loads pwm_duty_cycle. It is unchanged at all other times.
  - Writes to pwm_duty_cycle mid-period never affect the current period.
- **PWM waveform:** pwm = (duty_act == 8'hFF) | (cnt < duty_act).
  - 0x00 gives constant low.
  - 0xFF gives constant high with no low cycle at the wrap.
  - Otherwise the waveform is high for duty_act·CLK_DIV clocks of each 256·CLK_DIV clock period.
- **Per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:**
  - next_out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1'b1) : 1'b0.
  - out <= next_out on every clk.
- **period_start** is registered: period_start <= wrap.
- **No FSM beyond the counters.** The block is free-running from reset release and has no enable or stall input.
- **Reset:**
  - out = 16'h0000, period_start = 0.
  - presc = 0, cnt = 0, duty_act = 0.
  - Reset asserted mid-period clears everything immediately (asynchronously), regardless of phase.

## Timing
- **Enable/mode changes:** visible on out exactly 1 clk after the input changes. No period-boundary buffering for enables.
- **Duty changes:** take effect at the first wrap after the change. The first PWM-high cycle of the new period appears on out 1 clk after period_start rises.
- **out vs. counter:** out lags (cnt, duty_act) by one clk.
  - For 0 < duty < 255, out[i] (PWM, enabled) rises 1 clk after the wrap.
  - It falls 1 clk after the edge where cnt becomes duty_act.
- **First period after reset:** the first wrap occurs on the 256·CLK_DIV-th rising clk edge after rst_n deasserts.
  - Until then duty_act = 0, so PWM-mode outputs stay low.
  - Static-high outputs are valid 1 clk after reset release.
- **Period length:** exactly 256·CLK_DIV clks between successive period_start pulses.
- **Simultaneous events:** a duty write in the same cycle as a wrap is captured by that wrap; duty_act takes the new value.

## Test plan
1. **Reset:** hold rst_n=0 with all inputs 0xFF → out=0x0000 and period_start=0 throughout. After release, the first period_start arrives at clk edge 3328 (CLK_DIV=13).
2. **Static high:** en_reg_out_7_0=0x01, en_reg_pwm_7_0=0x00 → out=0x0001 one clk later. Set en_reg_out_15_8=0x80 → out=0x8001 one clk later. Clear both → 0x0000 one clk later.
3. **Half duty:** duty=0x80, out[0] enabled in PWM mode.
   - Out[0] is low until the first period_start.
   - It then rises 1 clk after period_start, stays high 1664 clks and low 1664 clks.
   - Period is 3328 clks, repeating.
4. **Extremes:**
   - duty=0x00 → out[0] is never high over 3 periods.
   - duty=0xFF → out[0] is constantly high across wraps, with zero low cycles.
   - out[15] in PWM mode with duty=0x01 → high for exactly 13 clks per period.
5. **Mid-period duty change:** duty=0x40; when cnt==100, write 0xC0.
   - The current period finishes with 832 clks high.
   - The next period has 2496 clks high.
   - A write coincident with the wrap is taken immediately.
6. **Reset mid-period:** with duty=0x80 and out[0] high, pull rst_n low → out=0 asynchronously.
   - After release, the next period_start is 3328 clks later.
   - Out[0] stays low until that pulse.
